serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the operand and result width in bits; legal range is 1..64.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid_i, input, 1 bit: operands present.
REQ-005 SHALL have port in_ready_o, output, 1 bit: block can accept operands.
REQ-006 SHALL have ports a_i and b_i, input, WIDTH bits each: the operands.
REQ-007 SHALL have port out_valid_o, output, 1 bit: result present.
REQ-008 SHALL have port out_ready_i, input, 1 bit: consumer takes the result.
REQ-009 SHALL have port sum_o, output, WIDTH bits: the result.
REQ-010 SHALL have port cout_o, output, 1 bit: carry out of the MSB.

Function
REQ-011 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-012 SHALL drive in_ready_o high only in IDLE, and out_valid_o high only in DONE; both are decoded from registered state.
REQ-013 SHALL accept operands on an edge where in_valid_i and in_ready_o are both high, latching a_i and b_i, clearing the carry register and the bit counter, and moving to RUN.
REQ-014 SHALL, in RUN, process one bit per cycle LSB first: sum bit = a^b^c, carry register <= majority(a,b,c), then shift both operand registers right by one.
REQ-015 SHALL shift the result bits into the sum register from the MSB end.
REQ-016 SHALL leave RUN on the WIDTH-th RUN edge, writing sum_o and cout_o and entering DONE.
REQ-017 SHALL assert out_valid_o exactly WIDTH cycles after the acceptance edge.
REQ-018 SHALL, in DONE, hold sum_o, cout_o and out_valid_o stable until out_ready_i is high, then return to IDLE on that edge.
REQ-019 SHALL not accept new operands in the cycle the result is taken; minimum issue interval is WIDTH+2 cycles.
REQ-020 SHALL ignore in_valid_i, a_i and b_i in RUN and DONE, and ignore out_ready_i in IDLE and RUN.
REQ-021 SHALL keep sum_o and cout_o at their last result after leaving DONE, until the next result is written.
REQ-022 SHALL, for WIDTH=1, spend exactly one cycle in RUN.
REQ-023 SHALL produce results modulo 2^WIDTH, with the overflow carry appearing on cout_o only.

Reset
REQ-024 SHALL, on any edge with rst_i high, force the state to IDLE, clear the counter, carry and operand registers, and set sum_o=0, cout_o=0, out_valid_o=0 and in_ready_o=1 in the following cycle.
REQ-025 SHALL, when reset is applied in RUN or DONE, abandon the operation with no partial result visible.

Configuration
REQ-026 SHALL, when macro SERIAL_ADD_SUB_EN is defined, add input port sub_i (1 bit), sampled at acceptance; when sub_i is 1, the latched b is ~b_i, the initial carry is 1, the result is a_i-b_i mod 2^WIDTH, and cout_o=1 means no borrow.
REQ-027 SHALL, without SERIAL_ADD_SUB_EN, have no sub_i port, have an initial carry of 0, and perform addition only.

Structure
REQ-028 SHALL place the FSM state typedef (IDLE/RUN/DONE) and the WIDTH default constant in package serial_add_pkg.
REQ-029 SHALL build the per-bit full adder from two instances of the existing half_adder sub-module (ports a_i, b_i, sum_o, cout_o), with the two carries ORed together.

Verification (WIDTH=8)
REQ-030 SHALL cover 0x5A+0x3C -> sum_o=0x96, cout_o=0, with out_valid_o rising 8 cycles after acceptance.
REQ-031 SHALL cover 0xFF+0x01 -> sum_o=0x00, cout_o=1; and 0x00+0x00 -> sum_o=0x00, cout_o=0.
REQ-032 SHALL cover backpressure: out_ready_i low for 5 cycles in DONE -> sum_o, cout_o and out_valid_o stable, in_ready_o=0 throughout, then IDLE one cycle after out_ready_i rises.
REQ-033 SHALL cover reset mid-operation: rst_i high at the 4th RUN cycle -> next cycle IDLE with sum_o=0, out_valid_o=0, in_ready_o=1; a fresh 0x01+0x01 then yields 0x02.
REQ-034 SHALL cover SERIAL_ADD_SUB_EN: 0x10-0x01 -> sum_o=0x0F, cout_o=1; and 0x01-0x02 -> sum_o=0xFF, cout_o=0.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder; two of these form the serial full adder.
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i;
    assign cout_o = a_i & b_i;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder with valid/ready handshake, LSB first, one bit per cycle.
// Define SERIAL_ADD_SUB_EN to add the sub_i port and a-b mode.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub_i,
`endif
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_next;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             s0, c0, bit_sum, c1, bit_cout;

    half_adder u_ha0 (.a_i(a_q[0]), .b_i(b_q[0]),   .sum_o(s0),      .cout_o(c0));
    half_adder u_ha1 (.a_i(s0),     .b_i(carry_q),  .sum_o(bit_sum), .cout_o(c1));

    assign bit_cout = c0 | c1;

    // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign sh_next = (sh_q >> 1) | (WIDTH'(bit_sum) << (WIDTH - 1));

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_o   <= '0;
            cout_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        a_q   <= a_i;
                        sh_q  <= '0;
                        cnt_q <= '0;
`ifdef SERIAL_ADD_SUB_EN
                        // a - b computed as a + ~b + 1; carry out 1 means no borrow.
                        b_q     <= sub_i ? ~b_i : b_i;
                        carry_q <= sub_i;
`else
                        b_q     <= b_i;
                        carry_q <= 1'b0;
`endif
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= bit_cout;
                    sh_q    <= sh_next;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        sum_o  <= sh_next;
                        cout_o <= bit_cout;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): vector table, corner sequences, random ops.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         sub_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] sum_o;
    logic         cout_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
`ifdef SERIAL_ADD_SUB_EN
        .sub_i       (sub_i),
`endif
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .sum_o       (sum_o),
        .cout_o      (cout_o)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] s;
        logic         c;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain (W+1)-bit arithmetic; subtraction as a + (2^W - 1 - b) + 1.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        logic [W:0] bb;
        bb = sub ? {1'b0, ~b} : {1'b0, b};
        return {1'b0, a} + bb + (W+1)'(sub);
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input logic [W-1:0] exp_s, input logic exp_c, input int hold,
                          input string name);
        int k;
        k = 0;
        while (!in_ready_o && k < 50) begin
            tick();
            k++;
        end
        chk({name, " ready_before"}, 64'(in_ready_o), 64'd1);
        a_i = a;
        b_i = b;
        sub_i = sub;
        in_valid_i = 1'b1;
        out_ready_i = 1'b0;
        tick();
        chk({name, " ready_after_accept"}, 64'(in_ready_o), 64'd0);
        // Junk on the input side while busy must be ignored.
        a_i = W'($urandom);
        b_i = W'($urandom);
        sub_i = 1'($urandom);
        k = 0;
        while (!out_valid_o && k < 200) begin
            tick();
            k++;
        end
        chk({name, " latency"}, 64'(k), 64'(W));
        chk({name, " sum"}, 64'(sum_o), 64'(exp_s));
        chk({name, " cout"}, 64'(cout_o), 64'(exp_c));
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({name, " hold_valid"}, 64'(out_valid_o), 64'd1);
            chk({name, " hold_sum"}, 64'(sum_o), 64'(exp_s));
            chk({name, " hold_cout"}, 64'(cout_o), 64'(exp_c));
            chk({name, " hold_ready"}, 64'(in_ready_o), 64'd0);
        end
        // in_valid still high on the take edge: must not be accepted there.
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk({name, " idle_valid"}, 64'(out_valid_o), 64'd0);
        chk({name, " idle_ready"}, 64'(in_ready_o), 64'd1);
        in_valid_i = 1'b0;
        tick();
        chk({name, " no_accept_on_take"}, 64'(in_ready_o), 64'd1);
        chk({name, " sum_kept"}, 64'(sum_o), 64'(exp_s));
        chk({name, " cout_kept"}, 64'(cout_o), 64'(exp_c));
    endtask

    vec_t vecs[5];
    vec_t svecs[2];

    initial begin
        logic [W-1:0] ra, rb;
        logic         rs;
        logic [W:0]   r;

        vecs[0] = '{a: 8'h5A, b: 8'h3C, sub: 1'b0, s: 8'h96, c: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, s: 8'h00, c: 1'b1};
        vecs[2] = '{a: 8'h00, b: 8'h00, sub: 1'b0, s: 8'h00, c: 1'b0};
        vecs[3] = '{a: 8'h80, b: 8'h80, sub: 1'b0, s: 8'h00, c: 1'b1};
        vecs[4] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, s: 8'h80, c: 1'b0};
        svecs[0] = '{a: 8'h10, b: 8'h01, sub: 1'b1, s: 8'h0F, c: 1'b1};
        svecs[1] = '{a: 8'h01, b: 8'h02, sub: 1'b1, s: 8'hFF, c: 1'b0};

        rst_i = 1'b1;
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        a_i = '0;
        b_i = '0;
        sub_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        chk("reset ready", 64'(in_ready_o), 64'd1);
        chk("reset valid", 64'(out_valid_o), 64'd0);
        chk("reset sum", 64'(sum_o), 64'd0);
        chk("reset cout", 64'(cout_o), 64'd0);

        // Vector table; vector 0 also exercises 5 cycles of backpressure.
        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].s, vecs[i].c,
                   (i == 0) ? 5 : 0, $sformatf("vec%0d", i));
        end

`ifdef SERIAL_ADD_SUB_EN
        for (int i = 0; i < 2; i++) begin
            run_op(svecs[i].a, svecs[i].b, svecs[i].sub, svecs[i].s, svecs[i].c,
                   1, $sformatf("subvec%0d", i));
        end
`endif

        // Reset during the 4th RUN cycle; sum_o currently holds 0x80.
        in_valid_i = 1'b1;
        a_i = 8'hFF;
        b_i = 8'hFF;
        sub_i = 1'b0;
        tick();
        in_valid_i = 1'b0;
        tick();
        tick();
        tick();
        chk("midrst busy", 64'(in_ready_o), 64'd0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("midrst ready", 64'(in_ready_o), 64'd1);
        chk("midrst valid", 64'(out_valid_o), 64'd0);
        chk("midrst sum", 64'(sum_o), 64'd0);
        chk("midrst cout", 64'(cout_o), 64'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("midrst no_result", 64'(out_valid_o), 64'd0);
        end
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0, "after_rst");

        // Random operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            r = model(ra, rb, rs);
            run_op(ra, rb, rs, r[W-1:0], r[W], int'($urandom_range(0, 3)),
                   $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
